bus_sink_regfile: RTL and testbench

//  Receiving end of the shared 32-bit datapath bus. Captures the bus value into the
//  16 x 32 general register file. The destination register comes from the IR
//  Ra/Rb/Rc fields, gated by gra/grb/grc and the rin strobe.

---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/reg_sel_decode.sv | 27 ++
 rtl/bus_sink_regfile.sv | 104 ++++++++++
 tb/tb_bus_sink_regfile.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared datapath bus definitions: widths, IR register-select field positions and
// the bit layout of the one-hot bus source drive strobes.
package cpu_bus_pkg;

  localparam int REG_SEL_W = 4;
  localparam int DW        = 32;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam int DRV_W     = 20;
  localparam int DRV_PC    = 0;
  localparam int DRV_IR    = 1;
  localparam int DRV_MDR   = 2;
  localparam int DRV_R0    = 3;
  localparam int DRV_R15   = 18;
  localparam int DRV_CSIGN = 19;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  function automatic logic multi_hot(input logic [DRV_W-1:0] v);
    return (v & (v - DRV_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Turns the IR Ra/Rb/Rc fields and the gra/grb/grc gates into one register index.
// Shared by the write side of the register file and the read-side select logic.
module reg_sel_decode
  import cpu_bus_pkg::*;
(
  input  logic [31:0]          ir,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  output logic [REG_SEL_W-1:0] sel,
  output logic                 sel_valid
);

  logic ir_unused;
  assign ir_unused = ^{ir[31:RA_HI+1], ir[RC_LO-1:0]};

  // gra outranks grb, which outranks grc.
  always_comb begin
    sel = '0;
    if (gra)      sel = ir[RA_HI:RA_LO];
    else if (grb) sel = ir[RB_HI:RB_LO];
    else if (grc) sel = ir[RC_HI:RC_LO];
  end

  assign sel_valid = gra | grb | grc;

endmodule

// File: rtl/bus_sink_regfile.sv
// Bus sink: captures buso into the general register file and flags bus contention.
// Optional macro R0_BAOUT_EN forces busi_r0 to zero while baout is high.
module bus_sink_regfile #(
  parameter int                         DW      = cpu_bus_pkg::DW,
  parameter int                         NREG    = 16,
  parameter logic [cpu_bus_pkg::DW-1:0] RST_VAL = '0
) (
  input  logic                                clock,
  input  logic                                clear_n,
  input  logic [DW-1:0]                       buso,
  input  logic [31:0]                         ir,
  input  logic                                gra,
  input  logic                                grb,
  input  logic                                grc,
  input  logic                                rin,
  input  logic                                baout,
  input  logic [cpu_bus_pkg::DRV_W-1:0]       drive_oh,
  input  logic                                err_clr,
  output logic [DW-1:0]                       busi_r0,
  output logic [DW-1:0]                       busi_r1,
  output logic [DW-1:0]                       busi_r2,
  output logic [DW-1:0]                       busi_r3,
  output logic [DW-1:0]                       busi_r4,
  output logic [DW-1:0]                       busi_r5,
  output logic [DW-1:0]                       busi_r6,
  output logic [DW-1:0]                       busi_r7,
  output logic [DW-1:0]                       busi_r8,
  output logic [DW-1:0]                       busi_r9,
  output logic [DW-1:0]                       busi_r10,
  output logic [DW-1:0]                       busi_r11,
  output logic [DW-1:0]                       busi_r12,
  output logic [DW-1:0]                       busi_r13,
  output logic [DW-1:0]                       busi_r14,
  output logic [DW-1:0]                       busi_r15,
  output logic [cpu_bus_pkg::REG_SEL_W-1:0]   wr_idx,
  output logic                                wr_valid,
  output logic                                err_multi
);

  import cpu_bus_pkg::*;

  logic [DW-1:0]        regs [NREG];
  logic [REG_SEL_W-1:0] sel;
  logic                 sel_valid;
  logic                 we;

  reg_sel_decode u_sel (
    .ir        (ir),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  assign we = rin & sel_valid;

  // No write bypass: a register being written still shows its old value until the edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
      wr_idx   <= '0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= we;
      if (we) begin
        regs[sel] <= buso;
        wr_idx    <= sel;
      end
    end
  end

  // A fresh contention event beats a simultaneous clear so it is never missed.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                err_multi <= 1'b0;
    else if (multi_hot(drive_oh)) err_multi <= 1'b1;
    else if (err_clr)            err_multi <= 1'b0;
  end

`ifdef R0_BAOUT_EN
  assign busi_r0 = baout ? '0 : regs[0];
`else
  logic baout_unused;
  assign baout_unused = baout;
  assign busi_r0      = regs[0];
`endif

  assign busi_r1  = regs[1];
  assign busi_r2  = regs[2];
  assign busi_r3  = regs[3];
  assign busi_r4  = regs[4];
  assign busi_r5  = regs[5];
  assign busi_r6  = regs[6];
  assign busi_r7  = regs[7];
  assign busi_r8  = regs[8];
  assign busi_r9  = regs[9];
  assign busi_r10 = regs[10];
  assign busi_r11 = regs[11];
  assign busi_r12 = regs[12];
  assign busi_r13 = regs[13];
  assign busi_r14 = regs[14];
  assign busi_r15 = regs[15];

endmodule

// File: tb/tb_bus_sink_regfile.sv
// Directed self-checking bench for bus_sink_regfile; honours R0_BAOUT_EN when defined.
module tb_bus_sink_regfile;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] buso;
  logic [31:0] ir;
  logic        gra, grb, grc, rin, baout, err_clr;
  logic [19:0] drive_oh;
  logic [31:0] busi [16];
  logic [3:0]  wr_idx;
  logic        wr_valid;
  logic        err_multi;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bus_sink_regfile dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .buso      (buso),
    .ir        (ir),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .rin       (rin),
    .baout     (baout),
    .drive_oh  (drive_oh),
    .err_clr   (err_clr),
    .busi_r0   (busi[0]),
    .busi_r1   (busi[1]),
    .busi_r2   (busi[2]),
    .busi_r3   (busi[3]),
    .busi_r4   (busi[4]),
    .busi_r5   (busi[5]),
    .busi_r6   (busi[6]),
    .busi_r7   (busi[7]),
    .busi_r8   (busi[8]),
    .busi_r9   (busi[9]),
    .busi_r10  (busi[10]),
    .busi_r11  (busi[11]),
    .busi_r12  (busi[12]),
    .busi_r13  (busi[13]),
    .busi_r14  (busi[14]),
    .busi_r15  (busi[15]),
    .wr_idx    (wr_idx),
    .wr_valid  (wr_valid),
    .err_multi (err_multi)
  );

  // Unused IR bits carry a fixed non-zero pattern so the decoder must ignore them.
  task automatic set_inputs(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                            input logic [2:0] g, input logic r, input logic [31:0] bus,
                            input logic [19:0] drv, input logic clr);
    ir       = {5'h15, ra, rb, rc, 15'h2AAA};
    {gra, grb, grc} = g;
    rin      = r;
    buso     = bus;
    drive_oh = drv;
    err_clr  = clr;
  endtask

  task automatic drive_cycle(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                             input logic [2:0] g, input logic r, input logic [31:0] bus,
                             input logic [19:0] drv, input logic clr);
    @(negedge clock);
    set_inputs(ra, rb, rc, g, r, bus, drv, clr);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
  endtask

  task automatic test_reset();
    drive_cycle(4'd2, 4'd0, 4'd0, 3'b100, 1'b1, 32'h77, 20'h00003, 1'b0);
    checks++;
    if (busi[2] !== 32'h77 || err_multi !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_setup: r2=%h err=%b expected 00000077 / 1", busi[2], err_multi);
    end
    #2 clear_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (busi[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_r%0d: got %h expected 00000000", i, busi[i]);
      end
    end
    checks++;
    if (err_multi !== 1'b0 || wr_valid !== 1'b0 || wr_idx !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: err=%b wr_valid=%b wr_idx=%0d expected 0/0/0",
               err_multi, wr_valid, wr_idx);
    end
    @(negedge clock);
    set_inputs(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
    clear_n = 1'b1;
  endtask

  task automatic test_write();
    drive_cycle(4'd5, 4'd1, 4'd2, 3'b100, 1'b1, 32'hDEADBEEF, 20'h0, 1'b0);
    checks++;
    if (busi[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_r5: got %h expected deadbeef", busi[5]);
    end
    checks++;
    if (wr_valid !== 1'b1 || wr_idx !== 4'd5) begin
      errors++;
      $display("[TB] FAIL write_status: wr_valid=%b wr_idx=%0d expected 1/5", wr_valid, wr_idx);
    end
    for (int i = 0; i < 16; i++) begin
      if (i != 5) begin
        checks++;
        if (busi[i] !== 32'h0) begin
          errors++;
          $display("[TB] FAIL write_other_r%0d: got %h expected 00000000", i, busi[i]);
        end
      end
    end
    // rin without any gate: no write, wr_valid drops, wr_idx holds
    drive_cycle(4'd6, 4'd6, 4'd6, 3'b000, 1'b1, 32'hFFFFFFFF, 20'h0, 1'b0);
    checks++;
    if (wr_valid !== 1'b0 || wr_idx !== 4'd5 || busi[6] !== 32'h0 || err_multi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_no_gate: wr_valid=%b wr_idx=%0d r6=%h err=%b expected 0/5/00000000/0",
               wr_valid, wr_idx, busi[6], err_multi);
    end
    drive_cycle(4'd1, 4'd2, 4'd12, 3'b001, 1'b1, 32'h8000_0001, 20'h0, 1'b0);
    checks++;
    if (busi[12] !== 32'h8000_0001 || wr_idx !== 4'd12 || busi[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL write_grc: r12=%h wr_idx=%0d r1=%h expected 80000001/12/00000000",
               busi[12], wr_idx, busi[1]);
    end
    idle_cycle();
  endtask

  task automatic test_priority();
    drive_cycle(4'd0, 4'd9, 4'd0, 3'b010, 1'b1, 32'h9999, 20'h0, 1'b0);
    drive_cycle(4'd3, 4'd9, 4'd0, 3'b110, 1'b1, 32'h1234, 20'h0, 1'b0);
    checks++;
    if (busi[3] !== 32'h1234 || busi[9] !== 32'h9999 || wr_idx !== 4'd3) begin
      errors++;
      $display("[TB] FAIL prio_ra_rb: r3=%h r9=%h wr_idx=%0d expected 00001234/00009999/3",
               busi[3], busi[9], wr_idx);
    end
    drive_cycle(4'd0, 4'd10, 4'd11, 3'b011, 1'b1, 32'hABCD, 20'h0, 1'b0);
    checks++;
    if (busi[10] !== 32'hABCD || busi[11] !== 32'h0 || wr_idx !== 4'd10) begin
      errors++;
      $display("[TB] FAIL prio_rb_rc: r10=%h r11=%h wr_idx=%0d expected 0000abcd/00000000/10",
               busi[10], busi[11], wr_idx);
    end
    idle_cycle();
  endtask

  task automatic test_multi_drive();
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h00009, 1'b0);
    checks++;
    if (err_multi !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_set: got %b expected 1", err_multi);
    end
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
    checks++;
    if (err_multi !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_sticky: got %b expected 1", err_multi);
    end
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b1);
    checks++;
    if (err_multi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL multi_clear: got %b expected 0", err_multi);
    end
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h00003, 1'b1);
    checks++;
    if (err_multi !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_clr_vs_set: got %b expected 1", err_multi);
    end
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h80000, 1'b1);
    checks++;
    if (err_multi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL multi_onehot_clear: got %b expected 0", err_multi);
    end
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h80000, 1'b0);
    checks++;
    if (err_multi !== 1'b0) begin
      errors++;
      $display("[TB] FAIL multi_onehot_legal: got %b expected 0", err_multi);
    end
    idle_cycle();
  endtask

  task automatic test_r0_baout();
    logic [31:0] exp_masked;
`ifdef R0_BAOUT_EN
    exp_masked = 32'h0;
`else
    exp_masked = 32'h55;
`endif
    drive_cycle(4'd0, 4'd0, 4'd0, 3'b100, 1'b1, 32'h55, 20'h0, 1'b0);
    @(negedge clock);
    set_inputs(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
    baout = 1'b1;
    #1;
    checks++;
    if (busi[0] !== exp_masked) begin
      errors++;
      $display("[TB] FAIL r0_baout_high: got %h expected %h", busi[0], exp_masked);
    end
    baout = 1'b0;
    #1;
    checks++;
    if (busi[0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL r0_baout_low: got %h expected 00000055", busi[0]);
    end
  endtask

  task automatic test_read_during_write();
    drive_cycle(4'd7, 4'd0, 4'd0, 3'b100, 1'b1, 32'hA, 20'h0, 1'b0);
    @(negedge clock);
    set_inputs(4'd7, 4'd0, 4'd0, 3'b100, 1'b1, 32'hB, 20'h0, 1'b0);
    #1;
    checks++;
    if (busi[7] !== 32'hA) begin
      errors++;
      $display("[TB] FAIL rdw_before_edge: got %h expected 0000000a", busi[7]);
    end
    @(posedge clock);
    #1;
    checks++;
    if (busi[7] !== 32'hB) begin
      errors++;
      $display("[TB] FAIL rdw_after_edge: got %h expected 0000000b", busi[7]);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_write();
    @(negedge clock);
    set_inputs(4'd4, 4'd0, 4'd0, 3'b100, 1'b1, 32'hFFFF, 20'h0, 1'b0);
    #2 clear_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (busi[4] !== 32'h0 || busi[5] !== 32'h0 || wr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_write: r4=%h r5=%h wr_valid=%b expected 00000000/00000000/0",
               busi[4], busi[5], wr_valid);
    end
    @(negedge clock);
    set_inputs(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
    clear_n = 1'b1;
    idle_cycle();
    checks++;
    if (busi[4] !== 32'h0 || wr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_write_after: r4=%h wr_valid=%b expected 00000000/0",
               busi[4], wr_valid);
    end
  endtask

  initial begin
    clear_n = 1'b0;
    baout   = 1'b0;
    set_inputs(4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 32'h0, 20'h0, 1'b0);
    #12 clear_n = 1'b1;
    test_reset();
    test_write();
    test_priority();
    test_multi_drive();
    test_r0_baout();
    test_read_during_write();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
